// File: rtl/router_param_top.sv
// Packet router: one byte stream is steered into N_CH per-channel FIFOs, and the parity byte is checked.
// Optional macro ROUTER_SOFT_RESET_EN adds a per-channel flush when a channel goes unread for too long.
module router_param_top #(
  parameter int unsigned N_CH    = 3,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   pkt_valid,
  input  logic [N_CH-1:0]        read_enb,
  output logic [N_CH*DATA_W-1:0] data_out,
  output logic [N_CH-1:0]        vld_out,
  output logic                   err,
  output logic                   busy
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned CH_W   = 2;
  localparam int unsigned WORD_W = DATA_W + 1;

  typedef enum logic [3:0] {
    DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, LOAD_PARITY, FIFO_FULL_STATE,
    LOAD_AFTER_FULL, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, DROP_PACKET
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hdr_q, hdr_d, hold_q, hold_d, par_q, par_d, calc_q, calc_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic              err_q, err_d, done_q, done_d;

  logic [WORD_W-1:0] mem_q    [N_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_CH];
  logic [PTR_W-1:0]  rd_ptr_q [N_CH];
  logic [CNT_W-1:0]  cnt_q    [N_CH];
  logic [DATA_W-1:0] dout_q   [N_CH];

  // Status vectors padded to the full 2-bit address space so ch_q can index them directly.
  logic [3:0]        empty_c, full_c, rd_c, flush_c;
  logic [N_CH-1:0]   wr_c;
  logic              wr_en_c, can_wr_c, addr_ok_c;
  logic [WORD_W-1:0] wr_word_c;

  always_comb begin
    empty_c = '1;
    full_c  = '0;
    rd_c    = '0;
    for (int k = 0; k < N_CH; k++) begin
      empty_c[k] = (cnt_q[k] == '0);
      full_c[k]  = (cnt_q[k] == CNT_W'(DEPTH));
      rd_c[k]    = read_enb[k] && (cnt_q[k] != '0);
    end
  end

  assign can_wr_c  = !full_c[ch_q] || rd_c[ch_q];
  assign addr_ok_c = 32'(data_in[1:0]) < N_CH;

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    hold_d    = hold_q;
    par_d     = par_q;
    calc_d    = calc_q;
    ch_d      = ch_q;
    err_d     = err_q;
    done_d    = done_q;
    wr_en_c   = 1'b0;
    wr_word_c = '0;
    unique case (state_q)
      DECODE_ADDRESS: if (pkt_valid) begin
        hdr_d  = data_in;
        calc_d = data_in;
        ch_d   = data_in[1:0];
        err_d  = 1'b0;
        done_d = 1'b0;
        if (!addr_ok_c)                state_d = DROP_PACKET;
        else if (empty_c[data_in[1:0]]) state_d = LOAD_FIRST_DATA;
        else                           state_d = WAIT_TILL_EMPTY;
      end
      WAIT_TILL_EMPTY: if (empty_c[ch_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA: begin
        wr_en_c   = 1'b1;
        wr_word_c = {1'b1, hdr_q};
        state_d   = LOAD_DATA;
      end
      LOAD_DATA: if (pkt_valid) begin
        calc_d = calc_q ^ data_in;
        if (can_wr_c) begin
          wr_en_c   = 1'b1;
          wr_word_c = {1'b0, data_in};
        end else begin
          hold_d  = data_in;
          state_d = FIFO_FULL_STATE;
        end
      end else begin
        par_d   = data_in;
        state_d = LOAD_PARITY;
      end
      FIFO_FULL_STATE: if (!full_c[ch_q]) state_d = done_q ? DECODE_ADDRESS : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        wr_en_c   = 1'b1;
        wr_word_c = {1'b0, hold_q};
        if (pkt_valid) begin
          state_d = LOAD_DATA;
        end else begin
          par_d   = data_in;
          state_d = LOAD_PARITY;
        end
      end
      LOAD_PARITY: if (can_wr_c) begin
        wr_en_c   = 1'b1;
        wr_word_c = {1'b0, par_q};
        state_d   = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        err_d = (calc_q != par_q);
        if (full_c[ch_q]) begin
          done_d  = 1'b1;
          state_d = FIFO_FULL_STATE;
        end else begin
          state_d = DECODE_ADDRESS;
        end
      end
      DROP_PACKET: if (!pkt_valid) begin
        err_d   = 1'b1;
        state_d = DECODE_ADDRESS;
      end
      default: state_d = DECODE_ADDRESS;
    endcase
    // A flush of the channel being loaded abandons the rest of that packet.
    if (flush_c[ch_q] && state_q != DECODE_ADDRESS && state_q != DROP_PACKET) begin
      wr_en_c = 1'b0;
      state_d = DECODE_ADDRESS;
    end
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++)
      wr_c[k] = wr_en_c && (ch_q == CH_W'(k)) && !flush_c[k] && (!full_c[k] || rd_c[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DECODE_ADDRESS;
      hdr_q   <= '0;
      hold_q  <= '0;
      par_q   <= '0;
      calc_q  <= '0;
      ch_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      hold_q  <= hold_d;
      par_q   <= par_d;
      calc_q  <= calc_d;
      ch_q    <= ch_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++)
      if (wr_c[k]) mem_q[k][wr_ptr_q[k]] <= wr_word_c;
  end

  // Per-channel pointers, occupancy and registered read port
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (reset || flush_c[k]) begin
        wr_ptr_q[k] <= '0;
        rd_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
        dout_q[k]   <= '0;
      end else begin
        if (wr_c[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
        if (rd_c[k]) begin
          dout_q[k]   <= mem_q[k][rd_ptr_q[k]][DATA_W-1:0];
          rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
        end
        cnt_q[k] <= cnt_q[k] + CNT_W'(wr_c[k]) - CNT_W'(rd_c[k]);
      end
    end
  end

`ifdef ROUTER_SOFT_RESET_EN
  logic [7:0] timer_q [N_CH];

  // Counts consecutive cycles a channel holds data that nobody reads.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N_CH; k++) begin
      if (reset || flush_c[k] || !vld_out[k] || read_enb[k]) timer_q[k] <= '0;
      else                                                     timer_q[k] <= timer_q[k] + 1'b1;
    end
  end

  always_comb begin
    flush_c = '0;
    for (int k = 0; k < N_CH; k++)
      flush_c[k] = vld_out[k] && !read_enb[k] && (timer_q[k] == 8'(TIMEOUT - 1));
  end
`else
  assign flush_c = '0;
`endif

  for (genvar k = 0; k < N_CH; k++) begin : g_out
    assign data_out[k*DATA_W +: DATA_W] = dout_q[k];
    assign vld_out[k]                   = !empty_c[k];
  end

  assign err  = err_q;
  assign busy = (state_q != DECODE_ADDRESS) && (state_q != LOAD_DATA);

endmodule

// File: tb/tb_router_param_top.sv
// Self-checking bench for router_param_top: packets are modelled as byte queues with XOR parity,
// and each channel's drained bytes are compared with the bytes the model says it must hold.
module tb_router_param_top;
  localparam int unsigned N_CH    = 3;
  localparam int unsigned DW      = 8;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned TIMEOUT = 30;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [DW-1:0]        data_in;
  logic                 pkt_valid;
  logic [N_CH-1:0]      read_enb;
  logic [N_CH*DW-1:0]   data_out;
  logic [N_CH-1:0]      vld_out;
  logic                 err;
  logic                 busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  router_param_top #(.N_CH(N_CH), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .pkt_valid(pkt_valid), .read_enb(read_enb),
    .data_out(data_out), .vld_out(vld_out), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Build header, len random payload bytes and the XOR parity (inverted-ish when corrupt).
  task automatic make_pkt(input int addr, input int len, input bit corrupt);
    logic [7:0] p, b;
    pkt_q = {};
    pkt_q.push_back({6'(len), 2'(addr)});
    p = pkt_q[0];
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt_q.push_back(b);
      p = p ^ b;
    end
    if (corrupt) p = p ^ 8'($urandom_range(1, 255));
    pkt_q.push_back(p);
  endtask

  // Present one byte and hold it until an edge at which busy was low.
  task automatic send_byte(input logic [7:0] b, input logic v);
    bit bz;
    int k;
    data_in = b;
    pkt_valid = v;
    k = 0;
    do begin
      @(negedge clk); bz = busy;
      @(posedge clk); #1; k++;
    end while (bz && k < 300);
    if (bz) begin
      n_tests++; n_fail++;
      $display("FAIL send_byte_stall: busy=%0b after %0d cycles, required 0", bz, k);
    end
  endtask

  // Legal packets follow busy; dropped packets stream one byte per cycle after the header.
  task automatic send_pkt();
    if (int'(pkt_q[0][1:0]) < N_CH) begin
      for (int i = 0; i < pkt_q.size(); i++) send_byte(pkt_q[i], i != pkt_q.size() - 1);
    end else begin
      send_byte(pkt_q[0], 1'b1);
      for (int i = 1; i < pkt_q.size(); i++) begin
        data_in = pkt_q[i];
        pkt_valid = (i != pkt_q.size() - 1);
        @(posedge clk); #1;
      end
    end
    data_in = '0;
    pkt_valid = 1'b0;
  endtask

  task automatic drain(input int ch, input int n);
    bit v;
    int k;
    got_q = {};
    k = 0;
    while (got_q.size() < n && k < 400) begin
      @(negedge clk); read_enb[ch] = 1'b1; v = vld_out[ch];
      @(posedge clk); #1; k++;
      if (v) got_q.push_back(data_out[ch*DW +: DW]);
    end
    read_enb = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; data_in = '0; pkt_valid = 1'b0; read_enb = '0;
    idle(3);
    n_tests++; if (vld_out !== '0) begin n_fail++; $display("FAIL reset_vld: got %b required 0", vld_out); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_dout: got %h required 0", data_out); end
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    pkt_q = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33};
    exp_q = pkt_q;
    send_pkt();
    idle(3);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", err); end
    n_tests++; if (vld_out !== 3'b010) begin n_fail++; $display("FAIL basic_vld: got %b required 010", vld_out); end
    drain(1, 5);
    n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL basic_count: got %0d required 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL basic_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    n_tests++; if (vld_out[1] !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b required 0", vld_out[1]); end
  endtask

  task automatic test_bad_parity();
    pkt_q = {8'h0D, 8'h11, 8'h22, 8'h33, 8'h00};
    exp_q = pkt_q;
    send_pkt();
    idle(1);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL badpar_err_early: got %b required 0", err); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL badpar_busy_check: got %b required 1", busy); end
    idle(1);
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL badpar_err: got %b required 1", err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL badpar_busy_idle: got %b required 0", busy); end
    drain(1, 5);
    n_tests++; if (got_q.size() != 5) begin n_fail++; $display("FAIL badpar_count: got %0d required 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_tests++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL badpar_byte%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_illegal_addr();
    make_pkt(3, 2, 1'b0);
    send_pkt();
    idle(3);
    n_tests++; if (vld_out !== '0) begin n_fail++; $display("FAIL drop_vld: got %b required 0", vld_out); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL drop_err: got %b required 1", err); end
    make_pkt(0, 3, 1'b0);
    exp_q = pkt_q;
    send_pkt();
    idle(3);
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL after_drop_err: got %b required 0", err); end
    n_tests++; if (vld_out !== 3'b001) begin n_fail++; $display("FAIL after_drop_vld: got %b required 001", vld_out); end
    drain(0, exp_q.size());
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL after_drop_data: got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_fifo_full();
    make_pkt(2, 20, 1'b0);
    exp_q = pkt_q;
    fork
      send_pkt();
      begin
        idle(20);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL full_busy: got %b required 1", busy); end
        n_tests++; if (vld_out[2] !== 1'b1) begin n_fail++; $display("FAIL full_vld: got %b required 1", vld_out[2]); end
        drain(2, 22);
      end
    join
    idle(3);
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL full_data: got %p required %p", got_q, exp_q); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b required 0", err); end
    n_tests++; if (vld_out !== '0) begin n_fail++; $display("FAIL full_empty: got %b required 0", vld_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e0[$];
    make_pkt(0, 4, 1'b0);
    e0 = pkt_q;
    send_pkt();
    make_pkt(1, 5, 1'b0);
    exp_q = pkt_q;
    send_pkt();
    idle(3);
    n_tests++; if (vld_out !== 3'b011) begin n_fail++; $display("FAIL b2b_vld: got %b required 011", vld_out); end
    drain(0, e0.size());
    n_tests++; if (got_q != e0) begin n_fail++; $display("FAIL b2b_ch0: got %p required %p", got_q, e0); end
    drain(1, exp_q.size());
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL b2b_ch1: got %p required %p", got_q, exp_q); end
  endtask

  task automatic test_wait_empty();
    make_pkt(2, 2, 1'b0);
    exp_q = pkt_q;
    send_pkt();
    idle(2);
    make_pkt(2, 3, 1'b1);
    foreach (pkt_q[i]) exp_q.push_back(pkt_q[i]);
    fork
      send_pkt();
      begin
        idle(8);
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wait_busy: got %b required 1", busy); end
        drain(2, exp_q.size());
      end
    join
    idle(3);
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL wait_data: got %p required %p", got_q, exp_q); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL wait_err: got %b required 1", err); end
  endtask

  task automatic test_random();
    int addr, len;
    bit bad, exp_err;
    for (int it = 0; it < 20; it++) begin
      addr = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      bad = ($urandom_range(0, 3) == 0);
      make_pkt(addr, len, bad);
      exp_q = pkt_q;
      exp_err = bad || (addr >= N_CH);
      send_pkt();
      idle(3);
      n_tests++;
      if (err !== exp_err) begin n_fail++; $display("FAIL rand%0d_err: got %b required %b", it, err, exp_err); end
      if (addr < N_CH) begin
        drain(addr, exp_q.size());
        n_tests++;
        if (got_q != exp_q) begin n_fail++; $display("FAIL rand%0d_data: got %p required %p", it, got_q, exp_q); end
      end
      n_tests++;
      if (vld_out !== '0) begin n_fail++; $display("FAIL rand%0d_empty: got %b required 0", it, vld_out); end
    end
  endtask

  task automatic test_reset_mid();
    make_pkt(1, 5, 1'b0);
    send_byte(pkt_q[0], 1'b1);
    send_byte(pkt_q[1], 1'b1);
    send_byte(pkt_q[2], 1'b1);
    reset = 1'b1;
    pkt_valid = 1'b0;
    idle(1);
    reset = 1'b0;
    n_tests++; if (vld_out !== '0) begin n_fail++; $display("FAIL rstmid_vld: got %b required 0", vld_out); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    n_tests++; if (data_out !== '0) begin n_fail++; $display("FAIL rstmid_dout: got %h required 0", data_out); end
    make_pkt(1, 2, 1'b0);
    exp_q = pkt_q;
    send_pkt();
    idle(3);
    drain(1, exp_q.size());
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL rstmid_data: got %p required %p", got_q, exp_q); end
    n_tests++; if (vld_out !== '0) begin n_fail++; $display("FAIL rstmid_empty: got %b required 0", vld_out); end
  endtask

  task automatic test_timeout();
    int rise, fall;
    rise = -1;
    fall = -1;
    make_pkt(0, 1, 1'b0);
    exp_q = pkt_q;
    fork
      send_pkt();
      for (int c = 0; c < 80; c++) begin
        @(posedge clk); #1;
        if (rise < 0 && vld_out[0]) rise = c;
        else if (rise >= 0 && fall < 0 && !vld_out[0]) fall = c;
      end
    join
`ifdef ROUTER_SOFT_RESET_EN
    n_tests++;
    if (fall - rise != int'(TIMEOUT) || rise < 0 || fall < 0) begin
      n_fail++; $display("FAIL timeout_cycles: got rise=%0d fall=%0d required span %0d", rise, fall, TIMEOUT);
    end
    n_tests++; if (data_out[DW-1:0] !== '0) begin n_fail++; $display("FAIL timeout_dout: got %h required 0", data_out[DW-1:0]); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy: got %b required 0", busy); end
`else
    n_tests++;
    if (rise < 0 || fall >= 0) begin n_fail++; $display("FAIL notimeout_vld: got rise=%0d fall=%0d required fall=-1", rise, fall); end
    drain(0, exp_q.size());
    n_tests++; if (got_q != exp_q) begin n_fail++; $display("FAIL notimeout_data: got %p required %p", got_q, exp_q); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_parity();
    test_illegal_addr();
    test_fifo_full();
    test_back_to_back();
    test_wait_empty();
    test_random();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
